// File: rtl/iter_div_unit.sv
// -----------------------------------------------------------------------------
// iter_div_unit
//   Multi-cycle integer divider for the execute stage. Retires RADIX_BITS
//   quotient bits per cycle and produces a {remainder, quotient} pair for
//   HI/LO. Supports signed (DIV) and unsigned (DIVU) operation, defines
//   divide-by-zero and MIN/-1 results, and can be cancelled with a flush.
//
// Ports:
//   cpu_clk_50M    : clock, rising edge
//   cpu_rst        : asynchronous active-high reset
//   start_i        : request, accepted when ready_o=1 (and no flush)
//   signed_i       : 1=signed, 0=unsigned; sampled at accept
//   dividend_i     : dividend, sampled at accept
//   divisor_i      : divisor, sampled at accept
//   flush_i        : cancel any operation, return to IDLE
//   ready_o        : idle, can accept start_i
//   busy_o         : iterating or sign-fixing (stall request)
//   result_valid_o : result available and held until result_ack_i
//   result_ack_i   : consumer takes the result
//   quotient_o     : quotient
//   remainder_o    : remainder
//   hilo_o         : {remainder_o, quotient_o}
//   div_by_zero_o  : divisor was zero (valid with result_valid_o)
//
// Handshake: a request transfers on a rising edge where start_i=1,
// ready_o=1 and flush_i=0; a result transfers on a rising edge where
// result_valid_o=1 and result_ack_i=1. Neither side may retract once
// raised, and start_i outside IDLE is simply not taken.
// -----------------------------------------------------------------------------
module iter_div_unit #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               flush_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               result_valid_o,
    input  logic               result_ack_i,
    output logic [WIDTH-1:0]   quotient_o,
    output logic [WIDTH-1:0]   remainder_o,
    output logic [2*WIDTH-1:0] hilo_o,
    output logic               div_by_zero_o
);

    localparam int ITERS = WIDTH / RADIX_BITS;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam int RW    = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               neg_quo_q, neg_quo_d;   // operand signs differ (signed op)
    logic               neg_rem_q, neg_rem_d;   // dividend negative (signed op)
    logic [WIDTH-1:0]   shf_q, shf_d;           // dividend bits out at top, quotient digits in at bottom
    logic [WIDTH-1:0]   dvs_q, dvs_d;           // divisor magnitude
    logic [WIDTH-1:0]   prem_q, prem_d;         // partial remainder, always < divisor
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

    // Operand conditioning at accept
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign a_neg = signed_i & dividend_i[WIDTH-1];
    assign b_neg = signed_i & divisor_i[WIDTH-1];
    assign a_mag = a_neg ? -dividend_i : dividend_i;
    assign b_mag = b_neg ? -divisor_i  : divisor_i;

    // One iteration: shift the next RADIX_BITS dividend bits into the
    // partial remainder and try the divisor multiples in parallel. The extra
    // top bit of each difference is its sign.
    logic [RW-1:0]         trial;
    logic [RW-1:0]         d1, d2, d3;
    logic [RW:0]           s1, s2, s3;
    logic [1:0]            digit;
    logic [WIDTH-1:0]      prem_next;

    assign trial = RW'({prem_q, shf_q[WIDTH-1 -: RADIX_BITS]});
    assign d1    = RW'(dvs_q);
    assign d2    = d1 << 1;
    assign d3    = d1 + d2;
    assign s1    = {1'b0, trial} - {1'b0, d1};
    assign s2    = {1'b0, trial} - {1'b0, d2};
    assign s3    = {1'b0, trial} - {1'b0, d3};

    always_comb begin
        digit     = 2'b00;
        prem_next = trial[WIDTH-1:0];
        if (RADIX_BITS == 2) begin
            if (!s3[RW]) begin
                digit     = 2'b11;
                prem_next = s3[WIDTH-1:0];
            end else if (!s2[RW]) begin
                digit     = 2'b10;
                prem_next = s2[WIDTH-1:0];
            end else if (!s1[RW]) begin
                digit     = 2'b01;
                prem_next = s1[WIDTH-1:0];
            end
        end else begin
            if (!s1[RW]) begin
                digit     = 2'b01;
                prem_next = s1[WIDTH-1:0];
            end
        end
    end

    // A non-negative difference is below the divisor, so its bits above
    // WIDTH are zero and only the sign bit carries information.
    logic unused_diff_hi;
    assign unused_diff_hi = ^{s1[RW-1:WIDTH], s2, s3};

    // Sign fix-up of the magnitude result
    logic [WIDTH-1:0] fixed_quo, fixed_rem;

    assign fixed_quo = neg_quo_q ? -shf_q : shf_q;
    assign fixed_rem = (neg_rem_q && (prem_q != '0)) ? -prem_q : prem_q;

    // Next-state / datapath control
    always_comb begin
        state_d   = state_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        shf_d     = shf_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;

        if (flush_i) begin
            // Cancel wins over start and ack; held outputs are left alone.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        shf_d     = a_mag;
                        dvs_d     = b_mag;
                        prem_d    = '0;
                        cnt_d     = '0;
                        if (divisor_i == '0) begin
                            quo_d   = '1;
                            rem_d   = dividend_i;
                            dbz_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            dbz_d   = 1'b0;
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    shf_d  = {shf_q[WIDTH-1-RADIX_BITS:0], digit[RADIX_BITS-1:0]};
                    prem_d = prem_next;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    quo_d   = fixed_quo;
                    rem_d   = fixed_rem;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (result_ack_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q   <= S_IDLE;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            shf_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            shf_q     <= shf_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign ready_o        = (state_q == S_IDLE);
    assign busy_o         = (state_q == S_CALC) || (state_q == S_FIX);
    assign result_valid_o = (state_q == S_DONE);
    assign quotient_o     = quo_q;
    assign remainder_o    = rem_q;
    assign hilo_o         = {rem_q, quo_q};
    assign div_by_zero_o  = dbz_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// -----------------------------------------------------------------------------
// tb_iter_div_unit
//   Bench for iter_div_unit: a 32-bit radix-4 instance and a 16-bit radix-2
//   instance sharing clock and reset. Directed vector tables with
//   hand-computed results, hand-written sequences for hold/ack, flush and
//   asynchronous reset, and a short randomised run against / and %.
// -----------------------------------------------------------------------------
module tb_iter_div_unit;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // ---------------- 32-bit radix-4 instance ----------------
    logic        start, sgn, flush, ack;
    logic [31:0] a, b;
    logic        ready, busy, valid, dbz;
    logic [31:0] q, r;
    logic [63:0] hilo;

    iter_div_unit #(.WIDTH(32), .RADIX_BITS(2)) dut32 (
        .cpu_clk_50M    (clk),
        .cpu_rst        (rst),
        .start_i        (start),
        .signed_i       (sgn),
        .dividend_i     (a),
        .divisor_i      (b),
        .flush_i        (flush),
        .ready_o        (ready),
        .busy_o         (busy),
        .result_valid_o (valid),
        .result_ack_i   (ack),
        .quotient_o     (q),
        .remainder_o    (r),
        .hilo_o         (hilo),
        .div_by_zero_o  (dbz)
    );

    // ---------------- 16-bit radix-2 instance ----------------
    logic        start16, sgn16, flush16, ack16;
    logic [15:0] a16, b16;
    logic        ready16, busy16, valid16, dbz16;
    logic [15:0] q16, r16;
    logic [31:0] hilo16;

    iter_div_unit #(.WIDTH(16), .RADIX_BITS(1)) dut16 (
        .cpu_clk_50M    (clk),
        .cpu_rst        (rst),
        .start_i        (start16),
        .signed_i       (sgn16),
        .dividend_i     (a16),
        .divisor_i      (b16),
        .flush_i        (flush16),
        .ready_o        (ready16),
        .busy_o         (busy16),
        .result_valid_o (valid16),
        .result_ack_i   (ack16),
        .quotient_o     (q16),
        .remainder_o    (r16),
        .hilo_o         (hilo16),
        .div_by_zero_o  (dbz16)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference results from the language operators
    function automatic void model32(input logic s, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] mq, output logic [31:0] mr, output logic md);
        md = 1'b0;
        if (y == 32'd0) begin
            mq = '1; mr = x; md = 1'b1;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            mq = x; mr = '0;
        end else if (s) begin
            mq = $signed(x) / $signed(y);
            mr = $signed(x) % $signed(y);
        end else begin
            mq = x / y;
            mr = x % y;
        end
    endfunction

    function automatic void model16(input logic s, input logic [15:0] x, input logic [15:0] y,
                                    output logic [15:0] mq, output logic [15:0] mr, output logic md);
        md = 1'b0;
        if (y == 16'd0) begin
            mq = '1; mr = x; md = 1'b1;
        end else if (s && x == 16'h8000 && y == 16'hFFFF) begin
            mq = x; mr = '0;
        end else if (s) begin
            mq = $signed(x) / $signed(y);
            mr = $signed(x) % $signed(y);
        end else begin
            mq = x / y;
            mr = x % y;
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Present one request in IDLE, scramble operands after accept, then wait
    // (bounded) for result_valid. lat = edges after accept at which valid is
    // first sampled high.
    task automatic run32(input logic s, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic saw_busy);
        @(negedge clk);
        start = 1'b1; sgn = s; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1));
        lat = 1;
        saw_busy = busy;
        while (!valid && lat < 100) begin
            @(negedge clk);
            lat++;
            saw_busy |= busy;
        end
    endtask

    task automatic ack32();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic run16(input logic s, input logic [15:0] x, input logic [15:0] y,
                         output int lat);
        @(negedge clk);
        start16 = 1'b1; sgn16 = s; a16 = x; b16 = y;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 1;
        while (!valid16 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack16_t();
        @(negedge clk);
        ack16 = 1'b1;
        @(negedge clk);
        ack16 = 1'b0;
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic        s;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ed;
    } vec_t;

    vec_t vt32[17];
    vec_t vt16[4];

    // ---------------- watchdog ----------------
    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int          lat;
        logic        sb;
        logic        seen;
        logic [31:0] mq, mr;
        logic        md;
        logic [15:0] mq16, mr16;
        logic        md16;

        vt32[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vt32[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vt32[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        vt32[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vt32[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vt32[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vt32[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  32'd0,          1'b0};
        vt32[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vt32[8]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
        vt32[9]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
        vt32[10] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
        vt32[11] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vt32[12] = '{1'b0, 32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
        vt32[13] = '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0};
        vt32[14] = '{1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0};
        vt32[15] = '{1'b1, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1};
        vt32[16] = '{1'b0, 32'h1234_5678,  32'h100,        32'h0012_3456,  32'h78,         1'b0};

        vt16[0]  = '{1'b0, 32'hFFFF, 32'h00FF, 32'h0101, 32'h0000, 1'b0};
        vt16[1]  = '{1'b1, 32'hFFF9, 32'h0002, 32'hFFFD, 32'hFFFF, 1'b0};
        vt16[2]  = '{1'b1, 32'h8000, 32'hFFFF, 32'h8000, 32'h0000, 1'b0};
        vt16[3]  = '{1'b0, 32'h0009, 32'h0000, 32'hFFFF, 32'h0009, 1'b1};

        rst = 1'b1;
        start = 1'b0; sgn = 1'b0; flush = 1'b0; ack = 1'b0; a = '0; b = '0;
        start16 = 1'b0; sgn16 = 1'b0; flush16 = 1'b0; ack16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset_outputs32", {hilo, q, r, 1'b0, dbz, valid, busy, ready},
              {64'd0, 32'd0, 32'd0, 5'b00001});
        check("reset_outputs16", {16'd0, hilo16, q16, r16, 1'b0, dbz16, valid16, busy16, ready16},
              {80'd0, 5'b00001});

        // Table: 32-bit radix-4
        for (int i = 0; i < 17; i++) begin
            run32(vt32[i].s, vt32[i].x, vt32[i].y, lat, sb);
            check($sformatf("v%0d_valid", i), 64'(valid), 64'd1);
            check($sformatf("v%0d_latency", i), 64'(lat), vt32[i].ed ? 64'd1 : 64'd18);
            check($sformatf("v%0d_quotient", i), 64'(q), 64'(vt32[i].eq));
            check($sformatf("v%0d_remainder", i), 64'(r), 64'(vt32[i].er));
            check($sformatf("v%0d_hilo", i), hilo, {vt32[i].er, vt32[i].eq});
            check($sformatf("v%0d_dbz", i), 64'(dbz), 64'(vt32[i].ed));
            check($sformatf("v%0d_busy_seen", i), 64'(sb), 64'(!vt32[i].ed));
            ack32();
            check($sformatf("v%0d_idle_after_ack", i), {62'd0, ready, valid}, 64'b10);
        end

        // Hold with ack low, operands toggling; then ack with start in the same cycle
        run32(1'b0, 32'd1000, 32'd9, lat, sb);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1));
            check($sformatf("hold_c%0d", i), {31'd0, valid, q, r}, {31'd1, 32'd111, 32'd1});
        end
        @(negedge clk);
        ack = 1'b1; start = 1'b1; sgn = 1'b0; a = 32'd50; b = 32'd5;
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        check("ack_start_idle", {61'd0, ready, busy, valid}, 64'b100);
        @(negedge clk);
        check("ack_start_ignored", {61'd0, ready, busy, valid}, 64'b100);
        run32(1'b0, 32'd50, 32'd5, lat, sb);
        check("restart_result", {q, r}, {32'd10, 32'd0});
        check("restart_latency", 64'(lat), 64'd18);
        ack32();

        // Flush in the 5th CALC cycle
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_calc_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_calc_idle", {61'd0, ready, busy, valid}, 64'b100);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            seen |= valid | busy;
        end
        check("flush_calc_no_result", 64'(seen), 64'd0);

        // Flush in FIX
        @(negedge clk);
        start = 1'b1; sgn = 1'b1; a = 32'hFFFF_FC18; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check("flush_fix_busy", {62'd0, busy, valid}, 64'b10);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_fix_idle", {61'd0, ready, busy, valid}, 64'b100);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            seen |= valid | busy;
        end
        check("flush_fix_no_result", 64'(seen), 64'd0);
        check("flush_keeps_outputs", {q, r}, {32'd10, 32'd0});

        // Asynchronous reset mid-CALC, with start held during reset
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'd1000; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_reset_outputs", {hilo, q, r, 1'b0, dbz, valid, busy, ready},
              {64'd0, 32'd0, 32'd0, 5'b00001});
        @(posedge clk);
        @(negedge clk);
        check("reset_start_ignored", {61'd0, ready, busy, valid}, 64'b100);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {61'd0, ready, busy, valid}, 64'b100);
        run32(1'b0, 32'hFFFF_FFFF, 32'd3, lat, sb);
        check("post_reset_result", {q, r}, {32'h5555_5555, 32'd0});
        check("post_reset_latency", 64'(lat), 64'd18);
        ack32();

        // Table: 16-bit radix-2
        for (int i = 0; i < 4; i++) begin
            run16(vt16[i].s, vt16[i].x[15:0], vt16[i].y[15:0], lat);
            check($sformatf("r2_v%0d_latency", i), 64'(lat), vt16[i].ed ? 64'd1 : 64'd18);
            check($sformatf("r2_v%0d_result", i), {31'd0, dbz16, hilo16},
                  {31'd0, vt16[i].ed, vt16[i].er[15:0], vt16[i].eq[15:0]});
            ack16_t();
        end

        // Randomised compare against / and %, both radices
        for (int i = 0; i < 150; i++) begin
            logic        rs;
            logic [31:0] rx, ry;
            rs = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 4))
                0: ry = 32'($urandom_range(0, 20));
                1: ry = ry >> $urandom_range(0, 31);
                2: rx = rx >> $urandom_range(0, 31);
                3: ry = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
                default: ;
            endcase
            model32(rs, rx, ry, mq, mr, md);
            run32(rs, rx, ry, lat, sb);
            check($sformatf("rnd32_%0d", i), {31'd0, dbz, q, r}, {31'd0, md, mq, mr});
            ack32();
        end
        for (int i = 0; i < 150; i++) begin
            logic        rs;
            logic [15:0] rx, ry;
            rs = 1'($urandom_range(0, 1));
            rx = 16'($urandom);
            ry = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ry = 16'($urandom_range(0, 20));
                1: ry = ry >> $urandom_range(0, 15);
                2: ry = 16'hFFFF - 16'($urandom_range(0, 5));
                default: ;
            endcase
            model16(rs, rx, ry, mq16, mr16, md16);
            run16(rs, rx, ry, lat);
            check($sformatf("rnd16_%0d", i), {31'd0, dbz16, 16'd0, q16, 16'd0, r16},
                  {31'd0, md16, 16'd0, mq16, 16'd0, mr16});
            ack16_t();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
